serial_ripple_subtractor: RTL and testbench



---
 rtl/serial_ripple_subtractor.sv | 128 ++++++++++++
 tb/tb_serial_ripple_subtractor.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_ripple_subtractor.sv
// serial_ripple_subtractor
//   Bit-serial unsigned subtractor: Diff = (A - B - Bin) mod 2^WIDTH and
//   Bout = (A < B + Bin), produced one bit per clock, LSB first, through a
//   single registered full-subtractor cell. One operation in flight at a time.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operands A, B, Bin valid
//   in_ready   block can accept operands (IDLE and not in reset)
//   A, B       minuend / subtrahend, unsigned, WIDTH bits
//   Bin        borrow-in
//   out_valid  Diff/Bout hold a completed result (DONE)
//   out_ready  consumer accepts result
//   Diff       result, WIDTH bits, registered
//   Bout       borrow-out, registered
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | shifting one bit per clock through the subtractor cell
// DONE  | result presented, out_valid=1, waiting for out_ready

module serial_ripple_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sr, b_sr, d_sr;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             a_bit, b_bit, d_bit, br_nxt;
  logic [WIDTH-1:0] d_shift;

  // Full-subtractor cell on the current LSBs
  assign a_bit  = a_sr[0];
  assign b_bit  = b_sr[0];
  assign d_bit  = a_bit ^ b_bit ^ br;
  assign br_nxt = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);

  // Result register fills from the MSB end; written as a shift/or so it also
  // holds for WIDTH=1, where there is no d_sr[WIDTH-1:1] slice.
  assign d_shift = (d_sr >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)        state_nxt = RUN;
      RUN:     if (cnt == CNT_LAST) state_nxt = DONE;
      DONE:    if (out_ready)       state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decode straight from state; in_ready is also masked
  // by rst so nothing is accepted while reset is held.
  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DONE);
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr <= '0;
      b_sr <= '0;
      d_sr <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      Diff <= '0;
      Bout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr <= A;
            b_sr <= B;
            br   <= Bin;
            d_sr <= '0;
            cnt  <= '0;
          end
        end
        RUN: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          d_sr <= d_shift;
          br   <= br_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            Diff <= d_shift;
            Bout <= br_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
module tb_serial_ripple_subtractor;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // WIDTH=4 instance
  logic       in_valid4, in_ready4, out_valid4, out_ready4, Bin4, Bout4;
  logic [3:0] A4, B4, Diff4;
  // WIDTH=1 instance
  logic       in_valid1, in_ready1, out_valid1, out_ready1, Bin1, Bout1;
  logic [0:0] A1, B1, Diff1;
  // WIDTH=8 instance
  logic       in_valid8, in_ready8, out_valid8, out_ready8, Bin8, Bout8;
  logic [7:0] A8, B8, Diff8;

  int n_vec = 0;
  int n_err = 0;

  serial_ripple_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .A(A4), .B(B4), .Bin(Bin4), .out_valid(out_valid4), .out_ready(out_ready4),
    .Diff(Diff4), .Bout(Bout4));

  serial_ripple_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .A(A1), .B(B1), .Bin(Bin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .Diff(Diff1), .Bout(Bout1));

  serial_ripple_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .A(A8), .B(B8), .Bin(Bin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .Diff(Diff8), .Bout(Bout8));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands to dut4 until accepted, then scramble the inputs so a
  // late re-sample would corrupt the result.
  task automatic accept4(input logic [3:0] a, input logic [3:0] b, input logic bin,
                         output bit ok);
    A4 = a; B4 = b; Bin4 = bin; in_valid4 = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = in_ready4;
      tick();
    end
    in_valid4 = 1'b0;
    if (!ok) chk("accept timeout", 32'd0, 32'd1);
    A4 = ~a; B4 = a ^ b ^ 4'h5; Bin4 = ~bin;
  endtask

  task automatic do_op4(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic bin, input int stall);
    bit         ok;
    int         lat;
    logic [4:0] t;
    t = {1'b0, a} - {1'b0, b} - {4'b0, bin};
    accept4(a, b, bin, ok);
    if (ok) begin
      out_ready4 = 1'b1;   // ignored while RUN
      lat = 0;
      while (!out_valid4 && lat < 40) begin
        tick();
        lat++;
      end
      chk({tag, " latency"}, lat, 32'd4);
      if (stall > 0) begin
        out_ready4 = 1'b0;
        for (int s = 0; s < stall; s++) begin
          in_valid4 = 1'b1;
          A4 = 4'd1;
          tick();
          chk({tag, " stall valid"}, out_valid4, 1'b1);
          chk({tag, " stall ready"}, in_ready4, 1'b0);
          chk({tag, " stall hold"}, {Bout4, Diff4}, t);
        end
        in_valid4  = 1'b0;
        out_ready4 = 1'b1;
      end
      chk({tag, " result"}, {Bout4, Diff4}, t);
      tick();
      chk({tag, " drop"}, out_valid4, 1'b0);
      chk({tag, " ready back"}, in_ready4, 1'b1);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int lat;
    logic [8:0] t8;
    logic [1:0] t1;
    logic [7:0] a8, b8;
    logic       bn;

    rst = 1'b1;
    in_valid4 = 0; out_ready4 = 0; A4 = 0; B4 = 0; Bin4 = 0;
    in_valid1 = 0; out_ready1 = 1; A1 = 0; B1 = 0; Bin1 = 0;
    in_valid8 = 0; out_ready8 = 1; A8 = 0; B8 = 0; Bin8 = 0;
    tick();
    tick();
    chk("reset in_ready", in_ready4, 1'b0);
    chk("reset out_valid", out_valid4, 1'b0);
    chk("reset result", {Bout4, Diff4}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post reset in_ready", in_ready4, 1'b1);

    do_op4("9-3", 4'd9, 4'd3, 1'b0, 0);
    do_op4("3-9", 4'd3, 4'd9, 1'b0, 0);
    do_op4("0-0-1", 4'd0, 4'd0, 1'b1, 0);

    // Reset during the second RUN cycle
    accept4(4'd9, 4'd3, 1'b0, ok);
    tick();
    rst = 1'b1;
    #1;
    chk("rst in_ready", in_ready4, 1'b0);
    tick();
    chk("rst out_valid", out_valid4, 1'b0);
    chk("rst result", {Bout4, Diff4}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst release in_ready", in_ready4, 1'b1);
    repeat (6) tick();
    chk("rst no stale result", out_valid4, 1'b0);
    do_op4("12-7-1", 4'd12, 4'd7, 1'b1, 0);

    do_op4("5-5 stall", 4'd5, 4'd5, 1'b0, 3);

    for (int i = 0; i < 512; i++)
      do_op4("sweep", 4'(i >> 5), 4'(i >> 1), i[0], int'($urandom_range(0, 2)));

    // WIDTH=1 exhaustive
    for (int i = 0; i < 8; i++) begin
      A1 = 1'(i >> 2); B1 = 1'(i >> 1); Bin1 = i[0];
      t1 = {1'b0, A1} - {1'b0, B1} - {1'b0, Bin1};
      in_valid1 = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
        ok = in_ready1;
        tick();
      end
      in_valid1 = 1'b0;
      A1 = ~A1; B1 = ~B1;
      lat = 0;
      while (!out_valid1 && lat < 40) begin
        tick();
        lat++;
      end
      chk("w1 latency", lat, 32'd1);
      chk("w1 result", {Bout1, Diff1}, t1);
      tick();
      chk("w1 drop", out_valid1, 1'b0);
    end

    // WIDTH=8 random
    for (int i = 0; i < 30; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); bn = 1'($urandom);
      if (i == 0) begin a8 = 8'd0; b8 = 8'd255; bn = 1'b1; end
      t8 = {1'b0, a8} - {1'b0, b8} - {8'b0, bn};
      A8 = a8; B8 = b8; Bin8 = bn; in_valid8 = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
        ok = in_ready8;
        tick();
      end
      in_valid8 = 1'b0;
      A8 = ~a8; B8 = a8;
      lat = 0;
      while (!out_valid8 && lat < 40) begin
        tick();
        lat++;
      end
      chk("w8 latency", lat, 32'd8);
      chk("w8 result", {Bout8, Diff8}, t8);
      tick();
      chk("w8 drop", out_valid8, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
